div_seq: RTL

- Multi-cycle radix-2 restoring divider with its own sequencing FSM.
- Serves the EX stage DIV/DIVU handshake: EX drives start_i, the operands and signed_div_i, and holds its stall request until ready_o.
- The result is packed as {remainder, quotient}; EX writes bits [63:32] to HI and bits [31:0] to LO.
- annul_i lets the pipeline cancel an in-flight divide on a flush or exception.

---
 rtl/div_seq_if.sv | 36 +++
 rtl/div_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// Handshake bundle between the EX stage and the sequential divider.
// With DIV_ZERO_FLAG_EN defined the bundle also carries the divide-by-zero flag.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic                  div_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_zero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_zero_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
`endif
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), result = {remainder, quotient}.
// Optional DIV_ZERO_FLAG_EN adds a registered div_zero_o flag for zero divisors.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  // Restoring keeps the partial remainder below the divisor, so its 33rd bit is
  // always zero and only the low DATA_W bits are stored.
  logic [DATA_W-1:0]   rem, rem_nxt;
  logic [DATA_W-1:0]   quo, quo_nxt;
  logic [DATA_W-1:0]   divisor, divisor_nxt;
  logic                neg_rem, neg_rem_nxt;
  logic                neg_quo, neg_quo_nxt;
  logic [2*DATA_W-1:0] result, result_nxt;
  logic                ready, ready_nxt;
  logic                div_zero, div_zero_nxt;

  logic [DATA_W:0]     trial;
  logic                neg_dvd, neg_dvs;

  assign neg_dvd = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign neg_dvs = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign trial   = {rem, quo[DATA_W-1]} - {1'b0, divisor};

  // NOTE: every variable driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rem_nxt      = rem;
    quo_nxt      = quo;
    divisor_nxt  = divisor;
    neg_rem_nxt  = neg_rem;
    neg_quo_nxt  = neg_quo;
    result_nxt   = result;
    ready_nxt    = ready;
    div_zero_nxt = div_zero;

    unique case (state)
      S_FREE: begin
        ready_nxt    = 1'b0;
        result_nxt   = '0;
        div_zero_nxt = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_nxt = S_BYZERO;
          end else begin
            state_nxt   = S_ON;
            divisor_nxt = neg_dvs ? -bus.opdata2_i : bus.opdata2_i;
            quo_nxt     = neg_dvd ? -bus.opdata1_i : bus.opdata1_i;
            rem_nxt     = '0;
            neg_rem_nxt = neg_dvd;
            neg_quo_nxt = neg_dvd ^ neg_dvs;
            cnt_nxt     = '0;
          end
        end
      end

      S_BYZERO: begin
        state_nxt    = S_END;
        result_nxt   = '0;
        ready_nxt    = 1'b1;
        div_zero_nxt = 1'b1;
      end

      S_ON: begin
        if (bus.annul_i || !bus.start_i) begin
          state_nxt  = S_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else if (cnt < CNT_W'(DATA_W)) begin
          // A borrow out of the trial subtraction means the divisor did not fit.
          if (!trial[DATA_W]) begin
            rem_nxt = trial[DATA_W-1:0];
            quo_nxt = {quo[DATA_W-2:0], 1'b1};
          end else begin
            rem_nxt = {rem[DATA_W-2:0], quo[DATA_W-1]};
            quo_nxt = {quo[DATA_W-2:0], 1'b0};
          end
          cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt  = S_END;
          ready_nxt  = 1'b1;
          result_nxt = {neg_rem ? -rem : rem, neg_quo ? -quo : quo};
        end
      end

      S_END: begin
        if (!bus.start_i) begin
          state_nxt    = S_FREE;
          ready_nxt    = 1'b0;
          result_nxt   = '0;
          div_zero_nxt = 1'b0;
        end
      end

      default: state_nxt = S_FREE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_rem  <= 1'b0;
      neg_quo  <= 1'b0;
      result   <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      quo      <= quo_nxt;
      divisor  <= divisor_nxt;
      neg_rem  <= neg_rem_nxt;
      neg_quo  <= neg_quo_nxt;
      result   <= result_nxt;
      ready    <= ready_nxt;
      div_zero <= div_zero_nxt;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_zero_o = div_zero;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
`endif

endmodule
